// File: rtl/rc4_prga_fsm.sv
// ---------------------------------------------------------------------------
// rc4_prga_fsm
// RC4 keystream generator (PRGA). After the key scheduler has filled the
// S-box RAM, each request walks the classic i/j swap and then reads
// S[(S[i]+S[j]) mod 256]. end_o is high in the cycle in which rdata_i
// carries that keystream byte.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start_i  : clear i, j, byte count and done; arm generator (IDLE only)
//   req_i    : request next keystream byte (sampled only in IDLE)
//   rdata_i  : S-box read data, valid one cycle after the address
//   addr_o   : S-box address
//   wdata_o  : S-box write data
//   wen_o    : S-box write enable
//   busy_o   : high in every state except IDLE
//   end_o    : one-cycle pulse, rdata_i holds the keystream byte
//   done_o   : MSG_LEN bytes produced; held until start_i or rst
//   cnt_o    : bytes produced since the last start_i
// ---------------------------------------------------------------------------
module rc4_prga_fsm #(
    parameter int MSG_LEN = 32,
    parameter int CNT_W   = $clog2(MSG_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             req_i,
    input  logic [7:0]       rdata_i,
    output logic [7:0]       addr_o,
    output logic [7:0]       wdata_o,
    output logic             wen_o,
    output logic             busy_o,
    output logic             end_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] LP_MSG_LEN = CNT_W'(MSG_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_I, S_LAT_I, S_RD_J, S_LAT_J,
        S_WR_I, S_WR_J, S_RD_T, S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [7:0]       r_i, r_j, r_si, r_sj;
    logic [7:0]       w_i_next, w_j_next, w_si_next, w_sj_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next, w_cnt_inc;
    logic             r_done, w_done_next;
    logic             r_armed, w_armed_next;

    logic [7:0]       r_addr, w_addr_next;
    logic [7:0]       r_wdata, w_wdata_next;
    logic             r_wen, r_busy, r_end;
    logic             w_wen_next, w_busy_next, w_end_next;

    logic             w_start, w_accept;

    // start_i only has an effect in IDLE so an in-flight swap stays intact;
    // start also takes priority over a simultaneous request.
    assign w_start   = (r_state == S_IDLE) && start_i;
    assign w_accept  = (r_state == S_IDLE) && !start_i && r_armed && req_i && !r_done;
    assign w_cnt_inc = r_cnt + 1'b1;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RD_I;
            S_RD_I:  w_state_next = S_LAT_I;
            S_LAT_I: w_state_next = S_RD_J;
            S_RD_J:  w_state_next = S_LAT_J;
            S_LAT_J: w_state_next = S_WR_I;
            S_WR_I:  w_state_next = S_WR_J;
            S_WR_J:  w_state_next = S_RD_T;
            S_RD_T:  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------
    always_comb begin
        w_i_next     = r_i;
        w_j_next     = r_j;
        w_si_next    = r_si;
        w_sj_next    = r_sj;
        w_cnt_next   = r_cnt;
        w_done_next  = r_done;
        w_armed_next = r_armed;
        if (w_start) begin
            w_i_next     = 8'd0;
            w_j_next     = 8'd0;
            w_cnt_next   = '0;
            w_done_next  = 1'b0;
            w_armed_next = 1'b1;
        end else if (w_accept) begin
            w_i_next = r_i + 8'd1;
        end
        case (r_state)
            S_LAT_I: begin
                w_si_next = rdata_i;
                w_j_next  = r_j + rdata_i;
            end
            S_LAT_J: w_sj_next = rdata_i;
            S_DONE: begin
                w_cnt_next = w_cnt_inc;
                if (w_cnt_inc == LP_MSG_LEN) w_done_next = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i     <= 8'd0;
            r_j     <= 8'd0;
            r_si    <= 8'd0;
            r_sj    <= 8'd0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_i     <= w_i_next;
            r_j     <= w_j_next;
            r_si    <= w_si_next;
            r_sj    <= w_sj_next;
            r_cnt   <= w_cnt_next;
            r_done  <= w_done_next;
            r_armed <= w_armed_next;
        end
    end

    // ---------------- output logic ----------------
    // Outputs are registered, so they are computed from the state being
    // entered and the datapath values that state will see.
    always_comb begin
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_wen_next   = 1'b0;
        w_busy_next  = (w_state_next != S_IDLE);
        w_end_next   = (w_state_next == S_DONE);
        case (w_state_next)
            S_RD_I: w_addr_next = w_i_next;
            S_RD_J: w_addr_next = w_j_next;
            S_WR_I: begin
                w_addr_next  = w_i_next;
                w_wdata_next = w_sj_next;
                w_wen_next   = 1'b1;
            end
            S_WR_J: begin
                w_addr_next  = w_j_next;
                w_wdata_next = w_si_next;
                w_wen_next   = 1'b1;
            end
            S_RD_T: w_addr_next = w_si_next + w_sj_next;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= 8'd0;
            r_wdata <= 8'd0;
            r_wen   <= 1'b0;
            r_busy  <= 1'b0;
            r_end   <= 1'b0;
        end else begin
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_wen   <= w_wen_next;
            r_busy  <= w_busy_next;
            r_end   <= w_end_next;
        end
    end

    assign addr_o  = r_addr;
    assign wdata_o = r_wdata;
    assign wen_o   = r_wen;
    assign busy_o  = r_busy;
    assign end_o   = r_end;
    assign done_o  = r_done;
    assign cnt_o   = r_cnt;

endmodule

// File: tb/tb_rc4_prga_fsm.sv
// ---------------------------------------------------------------------------
// tb_rc4_prga_fsm
// Two generator instances: a short message (MSG_LEN=4) for done/cnt and
// control-corner checks, and a long one for a full 256-byte run that wraps i.
// Each instance owns a 256x8 S-box RAM model with one-cycle read latency.
// Expected keystream bytes come from a software RC4 model and are queued
// when a request is issued; the end_o monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_rc4_prga_fsm;

    localparam int LEN_A = 4;
    localparam int LEN_B = 300;
    localparam int CW_A  = $clog2(LEN_A + 1);
    localparam int CW_B  = $clog2(LEN_B + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, req, sel, ram_init;

    logic [7:0]      a_rdata, a_addr, a_wdata;
    logic            a_wen, a_busy, a_end, a_done, a_start, a_req;
    logic [CW_A-1:0] a_cnt;
    logic [7:0]      b_rdata, b_addr, b_wdata;
    logic            b_wen, b_busy, b_end, b_done, b_start, b_req;
    logic [CW_B-1:0] b_cnt;

    assign a_start = start & ~sel;
    assign a_req   = req & ~sel;
    assign b_start = start & sel;
    assign b_req   = req & sel;

    rc4_prga_fsm #(.MSG_LEN(LEN_A)) dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .req_i(a_req), .rdata_i(a_rdata),
        .addr_o(a_addr), .wdata_o(a_wdata), .wen_o(a_wen), .busy_o(a_busy),
        .end_o(a_end), .done_o(a_done), .cnt_o(a_cnt)
    );

    rc4_prga_fsm #(.MSG_LEN(LEN_B)) dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .req_i(b_req), .rdata_i(b_rdata),
        .addr_o(b_addr), .wdata_o(b_wdata), .wen_o(b_wen), .busy_o(b_busy),
        .end_o(b_end), .done_o(b_done), .cnt_o(b_cnt)
    );

    // S-box RAM models (ram_init reloads the identity permutation)
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 256; k++) mem_a[k] <= 8'(k);
        end else if (a_wen) begin
            mem_a[a_addr] <= a_wdata;
        end
        a_rdata <= mem_a[a_addr];
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int k = 0; k < 256; k++) mem_b[k] <= 8'(k);
        end else if (b_wen) begin
            mem_b[b_addr] <= b_wdata;
        end
        b_rdata <= mem_b[b_addr];
    end

    // Signals of the instance currently under directed stimulus
    logic [7:0]  w_addr, w_wdata;
    logic        w_wen, w_busy, w_end, w_done;
    logic [15:0] w_cnt;
    assign w_addr  = sel ? b_addr  : a_addr;
    assign w_wdata = sel ? b_wdata : a_wdata;
    assign w_wen   = sel ? b_wen   : a_wen;
    assign w_busy  = sel ? b_busy  : a_busy;
    assign w_end   = sel ? b_end   : a_end;
    assign w_done  = sel ? b_done  : a_done;
    assign w_cnt   = sel ? 16'(b_cnt) : 16'(a_cnt);

    int tests = 0;
    int fails = 0;
    logic [7:0] sb_q [$];

    // Reference RC4 state
    logic [7:0] ms [256];
    logic [7:0] m_i, m_j;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        for (int k = 0; k < 256; k++) ms[k] = 8'(k);
        m_i = 8'd0;
        m_j = 8'd0;
    endtask

    task automatic model_step(output logic [7:0] ei, output logic [7:0] ej,
                              output logic [7:0] esi, output logic [7:0] esj,
                              output logic [7:0] et, output logic [7:0] eb);
        m_i    = m_i + 8'd1;
        esi    = ms[m_i];
        m_j    = m_j + esi;
        esj    = ms[m_j];
        ms[m_i] = esj;
        ms[m_j] = esi;
        et     = esi + esj;
        eb     = ms[et];
        ei     = m_i;
        ej     = m_j;
    endtask

    task automatic start_pulse();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        m_i = 8'd0;
        m_j = 8'd0;
    endtask

    // One request. accept=1: expect the full 8-cycle sequence and check the
    // RAM access pattern against the model. start_mid pulses start_i in RD_J.
    task automatic do_req(input bit accept, input bit start_mid);
        logic [7:0] ei, ej, esi, esj, et, eb;
        int n;
        ei = 0; ej = 0; esi = 0; esj = 0; et = 0; eb = 0;
        if (accept) begin
            model_step(ei, ej, esi, esj, et, eb);
            sb_q.push_back(eb);
        end
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        n = 1;
        if (!accept) begin
            check("req_dropped_busy", 32'(w_busy), 32'd0);
            repeat (10) @(negedge clk);
        end else begin
            check("rd_i_busy", 32'(w_busy), 32'd1);
            check("rd_i_addr", 32'(w_addr), 32'(ei));
            check("rd_i_wen",  32'(w_wen),  32'd0);
            while (!w_end && n < 20) begin
                @(negedge clk);
                n++;
                if (start_mid) start = (n == 3);
                case (n)
                    3: check("rd_j_addr", 32'(w_addr), 32'(ej));
                    5: begin
                        check("wr_i_addr",  32'(w_addr),  32'(ei));
                        check("wr_i_wdata", 32'(w_wdata), 32'(esj));
                        check("wr_i_wen",   32'(w_wen),   32'd1);
                    end
                    6: begin
                        check("wr_j_addr",  32'(w_addr),  32'(ej));
                        check("wr_j_wdata", 32'(w_wdata), 32'(esi));
                        check("wr_j_wen",   32'(w_wen),   32'd1);
                    end
                    7: begin
                        check("rd_t_addr", 32'(w_addr), 32'(et));
                        check("rd_t_wen",  32'(w_wen),  32'd0);
                    end
                    default: ;
                endcase
            end
            start = 1'b0;
            check("end_latency", 32'(n), 32'd8);
        end
    endtask

    // Scoreboard monitor: every end_o pulse must match a queued byte
    always @(negedge clk) begin
        if (!rst) begin
            if (a_end) begin
                check("a_end_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) check("a_keystream", 32'(a_rdata), 32'(sb_q.pop_front()));
            end
            if (b_end) begin
                check("b_end_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) check("b_keystream", 32'(b_rdata), 32'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int diffs;
        rst = 1'b1; start = 1'b0; req = 1'b0; sel = 1'b0; ram_init = 1'b1;
        model_init();
        repeat (3) @(negedge clk);
        ram_init = 1'b0;

        // Reset state
        check("rst_addr",  32'(a_addr),  32'd0);
        check("rst_wdata", 32'(a_wdata), 32'd0);
        check("rst_wen",   32'(a_wen),   32'd0);
        check("rst_busy",  32'(a_busy),  32'd0);
        check("rst_end",   32'(a_end),   32'd0);
        check("rst_done",  32'(a_done),  32'd0);
        check("rst_cnt",   32'(a_cnt),   32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        rst = 1'b0;

        // Disarmed: request ignored
        do_req(1'b0, 1'b0);

        // Identity S: i==j on the first byte, keystream 2 then 5
        start_pulse();
        do_req(1'b1, 1'b0);
        check("ieqj_mem_a1", 32'(mem_a[1]), 32'd1);
        do_req(1'b1, 1'b0);
        @(negedge clk);
        check("cnt_after_2", 32'(w_cnt), 32'd2);
        check("mem_a2_swapped", 32'(mem_a[2]), 32'd3);
        check("mem_a3_swapped", 32'(mem_a[3]), 32'd2);

        // MSG_LEN=4: done after 4th byte, 5th request dropped
        do_req(1'b1, 1'b0);
        @(negedge clk);
        check("done_after_3", 32'(w_done), 32'd0);
        check("cnt_after_3",  32'(w_cnt),  32'd3);
        do_req(1'b1, 1'b0);
        @(negedge clk);
        check("done_after_4", 32'(w_done), 32'd1);
        check("cnt_after_4",  32'(w_cnt),  32'd4);
        do_req(1'b0, 1'b0);
        check("cnt_after_5th", 32'(w_cnt), 32'd4);
        start_pulse();
        check("start_clr_done", 32'(w_done), 32'd0);
        check("start_clr_cnt",  32'(w_cnt),  32'd0);

        // Reset in WR_I abandons the swap
        do_req(1'b1, 1'b0);
        @(negedge clk); req = 1'b1;
        @(negedge clk); req = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_in_wr_i", 32'(w_wen), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_wen",  32'(w_wen),  32'd0);
        check("abort_busy", 32'(w_busy), 32'd0);
        check("abort_end",  32'(w_end),  32'd0);
        check("abort_cnt",  32'(w_cnt),  32'd0);
        check("abort_addr", 32'(w_addr), 32'd0);
        rst = 1'b0;
        do_req(1'b0, 1'b0);

        // start in RD_J ignored; start+req in IDLE only arms
        @(negedge clk); ram_init = 1'b1;
        @(negedge clk); ram_init = 1'b0;
        model_init();
        start_pulse();
        do_req(1'b1, 1'b1);
        @(negedge clk);
        check("cnt_after_mid_start", 32'(w_cnt), 32'd1);
        start = 1'b1; req = 1'b1;
        @(negedge clk);
        start = 1'b0; req = 1'b0;
        m_i = 8'd0; m_j = 8'd0;
        check("start_req_busy", 32'(w_busy), 32'd0);
        check("start_req_cnt",  32'(w_cnt),  32'd0);
        @(negedge clk);
        check("start_req_idle", 32'(w_busy), 32'd0);
        do_req(1'b1, 1'b0);
        do_req(1'b1, 1'b0);

        // Long instance: 256 bytes, i wraps 255 -> 0
        sel = 1'b1;
        @(negedge clk); ram_init = 1'b1;
        @(negedge clk); ram_init = 1'b0;
        model_init();
        start_pulse();
        for (int r = 0; r < 256; r++) do_req(1'b1, 1'b0);
        @(negedge clk);
        check("b_cnt_256", 32'(w_cnt), 32'd256);
        check("b_done_0",  32'(w_done), 32'd0);
        diffs = 0;
        for (int k = 0; k < 256; k++) if (mem_b[k] !== ms[k]) diffs++;
        check("b_sbox_final", 32'(diffs), 32'd0);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
